bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter family.
// Holds the arbiter state encoding, the bus width and the default sizing.
package bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int BUS_W         = 32;
    localparam int DEF_N_MASTERS = 4;
    localparam int DEF_TIMEOUT   = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant handshake between the bus masters and the central arbiter.
// The arbiter connects through the slave modport; the master side drives request/ready.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int IDX_W     = $clog2(N_MASTERS)
);

    logic [N_MASTERS-1:0] request;
    logic                 ready;
    logic [N_MASTERS-1:0] grant;
    logic [IDX_W-1:0]     owner;
    logic                 bus_busy;
    logic                 bus_error;

    modport master (
        output request,
        output ready,
        input  grant,
        input  owner,
        input  bus_busy,
        input  bus_error
    );

    modport slave (
        input  request,
        input  ready,
        output grant,
        output owner,
        output bus_busy,
        output bus_error
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from last+1.
// Kept generic so interrupt or DMA arbiters can share it.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N     = DEF_N_MASTERS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             valid
);

    // Walk offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        pick  = '0;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % N);
            if (request[cand]) begin
                pick  = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central round-robin arbiter for the shared system bus.
// Holds a grant until ready, withdrawal or watchdog abort, then rotates priority.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int IDX_W     = $clog2(N_MASTERS),
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);

    localparam logic [N_MASTERS-1:0] GRANT_ONE = N_MASTERS'(1);
    localparam logic [CNT_W-1:0]     WD_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     LAST_RST  = IDX_W'(N_MASTERS - 1);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     wd_q, wd_d;
    logic                 err_q, err_d;

    logic [IDX_W-1:0]     pick;
    logic                 pick_valid;

    logic                 owner_req;
    logic                 wd_expired;

    rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .request (bus.request),
        .last    (last_q),
        .pick    (pick),
        .valid   (pick_valid)
    );

    assign owner_req  = bus.request[owner_q];
    assign wd_expired = (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    grant_d = GRANT_ONE << pick;
                    owner_d = pick;
                    wd_d    = '0;
                end
            end
            OWNED: begin
                // ready beats withdrawal beats watchdog; only a pure timeout flags an error.
                if (bus.ready || !owner_req || wd_expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    wd_d    = '0;
                    err_d   = !bus.ready && owner_req && wd_expired;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;
    assign bus.bus_busy  = (state_q == OWNED);
    assign bus.bus_error = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int IW  = 2;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    // reference model state
    bit m_busy;
    int m_owner;
    int m_last;
    int m_age;
    bit m_err;

    bus_arbiter_if #(.N_MASTERS(N), .IDX_W(IW)) bif ();

    bus_arbiter #(
        .N_MASTERS (N),
        .IDX_W     (IW),
        .TIMEOUT   (TO),
        .CNT_W     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_age   = 0;
        m_err   = 1'b0;
    endfunction

    // One bus edge at transaction level: grant nearest requester after last,
    // close the transaction on ready, withdrawal, or after TO granted cycles.
    function automatic void model_step(input logic [N-1:0] req, input logic rdy);
        m_err = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!m_busy && req[idx]) begin
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_age   = 1;
                end
            end
        end else if (rdy || !req[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (m_age >= TO) begin
            m_busy = 1'b0;
            m_last = m_owner;
            m_err  = 1'b1;
        end else begin
            m_age++;
        end
    endfunction

    task automatic compare_model();
        logic [N-1:0] exp_grant;
        exp_grant = m_busy ? (N'(1) << m_owner) : '0;
        check_eq("grant", 32'(bif.grant), 32'(exp_grant));
        check_eq("bus_busy", 32'(bif.bus_busy), 32'(m_busy));
        check_eq("bus_error", 32'(bif.bus_error), 32'(m_err));
        if (m_busy)
            check_eq("owner", 32'(bif.owner), 32'(m_owner));
    endtask

    // Inputs change at negedge; outputs are checked at the following negedge.
    task automatic cycle(input logic [N-1:0] r, input logic rd);
        bif.request = r;
        bif.ready   = rd;
        @(posedge clk);
        model_step(r, rd);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        int gcnt;
        int ecnt;
        logic [N-1:0] req;
        logic         rdy;

        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bif.request = '0;
        bif.ready   = 1'b0;
        model_reset();

        @(negedge clk);
        check_eq("rst_grant", 32'(bif.grant), 32'h0);
        check_eq("rst_busy", 32'(bif.bus_busy), 32'h0);
        check_eq("rst_error", 32'(bif.bus_error), 32'h0);
        check_eq("rst_owner", 32'(bif.owner), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // single request, ready on the third granted edge
        cycle(4'b0001, 1'b0);
        check_eq("single_grant", 32'(bif.grant), 32'h1);
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b1);
        check_eq("single_done", 32'(bif.grant), 32'h0);
        check_eq("single_idle", 32'(bif.bus_busy), 32'h0);
        cycle(4'b0000, 1'b0);

        // watchdog: ready never comes
        gcnt = 0;
        ecnt = 0;
        for (int i = 0; i < TO + 4 && ecnt == 0; i++) begin
            cycle(4'b0010, 1'b0);
            if (bif.grant == 4'b0010) gcnt++;
            if (bif.bus_error) ecnt++;
        end
        check_eq("wd_cycles", 32'(gcnt), 32'(TO));
        check_eq("wd_err_seen", 32'(ecnt), 32'h1);
        cycle(4'b0100, 1'b0);
        check_eq("wd_err_pulse", 32'(bif.bus_error), 32'h0);
        check_eq("wd_next_grant", 32'(bif.grant), 32'h4);

        // reset in the middle of a grant drops it without a clock edge
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_grant", 32'(bif.grant), 32'h0);
        check_eq("async_rst_busy", 32'(bif.bus_busy), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle(4'b1111, 1'b0);
        check_eq("post_rst_grant", 32'(bif.grant), 32'h1);

        // all four requesting: strict rotation 0,1,2,3,0
        for (int k = 1; k <= N; k++) begin
            cycle(4'b1111, 1'b1);
            check_eq("rr_gap", 32'(bif.grant), 32'h0);
            cycle(4'b1111, 1'b0);
            check_eq("rr_order", 32'(bif.grant), 32'(1 << (k % N)));
        end
        cycle(4'b1111, 1'b1);

        // withdrawal by master 3 leaves last=3, so master 0 wins next
        cycle(4'b1000, 1'b0);
        check_eq("wd_own3", 32'(bif.grant), 32'h8);
        cycle(4'b0000, 1'b0);
        check_eq("withdraw_grant", 32'(bif.grant), 32'h0);
        check_eq("withdraw_noerr", 32'(bif.bus_error), 32'h0);
        cycle(4'b1001, 1'b0);
        check_eq("after_withdraw", 32'(bif.grant), 32'h1);
        cycle(4'b1001, 1'b1);
        cycle(4'b0000, 1'b0);

        // randomized traffic, with ready-starved phases to reach the watchdog
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            bit starved;
            starved = ((c / 400) % 3) == 2;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, starved ? 39 : 9) == 0) req[b] = ~req[b];
            rdy = starved ? 1'b0 : ($urandom_range(0, 3) == 0);
            cycle(req, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
